// File: rtl/multiplier_bus_port.sv
// rtl/multiplier_bus_port.sv - bus-loaded shift-add multiplier port with tri-state product readback
// Operands and start arrive as wr rising-edge events; the 2n-bit product is read back over the shared data bus.

module multiplier_bus_port #(
    parameter int n = 4
) (
    input  logic       clock,
    input  logic       nReset,
    input  logic [1:0] func,
    input  logic       wr,
    input  logic       rd,
    output logic       ready,
    inout  wire  [7:0] data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [n-1:0]       m_q, m_d;
    logic [n-1:0]       q_q, q_d;
    logic [2*n-1:0]     aq_q, aq_d;
    logic [2:0]         cnt_q, cnt_d;
    logic               wr_prev_q;

    logic               wr_event;
    logic [n:0]         sum;
    logic [2*n:0]       cq_shift;
    logic               rd_grant;

    assign wr_event = wr && !wr_prev_q;

    // Carry is folded into the shift: {C, A, Q} >> 1 with C refilled by 0.
    assign sum      = {1'b0, aq_q[2*n-1:n]} + (aq_q[0] ? {1'b0, m_q} : {(n+1){1'b0}});
    assign cq_shift = {sum, aq_q[n-1:0]};

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        q_d     = q_q;
        aq_d    = aq_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (wr_event) begin
                    case (func)
                        2'b00:   m_d = data[n-1:0];
                        2'b01:   q_d = data[n-1:0];
                        2'b10:   state_d = LOAD;
                        default: ;
                    endcase
                end
            end
            LOAD: begin
                aq_d    = {{n{1'b0}}, q_q};
                cnt_d   = 3'd0;
                state_d = RUN;
            end
            RUN: begin
                aq_d  = cq_shift[2*n:1];
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'(n - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!nReset) begin
            state_q   <= IDLE;
            m_q       <= '0;
            q_q       <= '0;
            aq_q      <= '0;
            cnt_q     <= '0;
            wr_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            q_q       <= q_d;
            aq_q      <= aq_d;
            cnt_q     <= cnt_d;
            wr_prev_q <= wr;
        end
    end

    assign ready    = (state_q == IDLE);
    assign rd_grant = rd && (func == 2'b11) && (state_q == IDLE);
    assign data     = rd_grant ? 8'(aq_q) : 8'bz;

endmodule

// File: doc/multiplier_bus_port.md
# multiplier_bus_port

Bus-side port of the shift-add multiplier. It captures the multiplicand M and the multiplier Q from the shared 8-bit bidirectional data bus, then runs an n-iteration add-shift multiply. It drives the 2n-bit product back onto the same bus when a read is requested. This block is the receiving end of the operand-load/product-read bus used by the board test harness, and it replaces fixed operand constants with bus-loaded values.

## Interface

Parameters:
- n, 4, operand width; legal range 1–4 so that the 2n-bit product fits the 8-bit bus.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- nReset  input  1  synchronous active-low reset, sampled on the rising edge of clock.
- func  input  2  bus function: 00 load M, 01 load Q, 10 start, 11 read product.
- wr  input  1  write strobe; its rising edge, sampled on clock, triggers the func 00/01/10 action.
- rd  input  1  read enable; used together with func 11.
- ready  output  1  1 = idle, so operands and product are accessible; 0 = multiply in progress.
- data  inout  8  shared bus; the block drives it only during a granted read, otherwise hi-Z.

## Operation

Registers:
- wr_d: previous wr sample.
- M[n-1:0]: multiplicand.
- Q[n-1:0]: staged multiplier.
- AQ[2n-1:0]: accumulator and multiplier, which holds the product when done.
- C: carry.
- cnt: iteration counter.
- state: one of IDLE, LOAD, RUN.

Reset, whenever nReset=0 at an edge:
- state=IDLE.
- M, Q, AQ, C, cnt and wr_d all 0.
- ready=1.
- data hi-Z.
- Reset takes priority over every other event, including mid-multiply. An aborted result is discarded and AQ reads 0.

Write event: wr=1 and wr_d=0 at an edge. Holding wr high produces exactly one event.

IDLE:
- Write event with func 00: M <= data[n-1:0].
- Write event with func 01: Q <= data[n-1:0].
- Write event with func 10: go to LOAD. M and Q are frozen from this point.
- Operand writes leave AQ unchanged, so the previous product stays readable.

LOAD (one cycle): AQ <= {n'b0, Q}, C <= 0, cnt <= 0, go to RUN.

RUN (n cycles), each cycle:
- If AQ[0]=1, {C, A} = A + M; otherwise {C, A} = {0, A}. A is AQ[2n-1:n].
- Then {C, AQ} is shifted right by one, with C refilling from 0.
- cnt increments. After the iteration where cnt=n-1, go to IDLE.

Arithmetic:
- The addition is unsigned, n+1 bits including C.
- The final AQ equals M*Q, unsigned and exact.
- There is no overflow, because 2n ≤ 8.

Events while busy (LOAD or RUN):
- Write events of any func are ignored and are not queued.
- Read requests return hi-Z.

Data drive:
- data = {(8-2n)'b0, AQ} exactly when rd=1, func=11 and state=IDLE. In all other cases data = 8'bz.
- This is combinational from registered state and the inputs.
- The bus driver must never drive while the external agent writes. The agent guarantees rd=0 whenever it drives data.

ready = (state == IDLE), taken from a registered state.

## Timing

- Write event sampled at edge k with func 10: ready=0 after edge k.
- Edge k+1: LOAD executes.
- Edges k+2 … k+n+1: RUN iterations.
- ready returns to 1 after edge k+n+1. Total busy time is n+1 cycles (5 for n=4).
- Product is valid and readable from the first cycle with ready=1.
- Operand capture: M or Q reflects data sampled at the write-event edge, and is visible the next cycle.
- Read latency: zero cycles. data is driven in the same cycle that rd, func=11 and IDLE all hold.
- A write event at the same edge that RUN finishes (cnt=n-1) is ignored, because state is not yet IDLE.
- A start event with no prior operand loads multiplies the current M and Q (0 after reset).
- A second start without new loads repeats the same multiply and gives the same result.

## Test plan

- Reset, then rd=1 with func=11 → data=8'h00, ready=1. With rd=0 → data is hi-Z.
- Load M=4'h6 and Q=4'hE, then start → ready low for exactly 5 cycles, then read data=8'h54 (84).
- Load M=4'hF and Q=4'hF, then start → read data=8'hE1. Load M=4'h0 and Q=4'h9, then start → data=8'h00.
- Start 6×14, then 2 cycles later issue a write event with func 00 and data=8'h03 → ignored, result still 8'h54. A read while busy gives hi-Z.
- Start 6×14, then assert nReset=0 for one cycle during RUN → ready=1 on the next cycle, and a read gives 8'h00. M=0 and Q=0, so a following start yields 8'h00.
- Hold wr high for 4 cycles with func 10 → exactly one multiply, with ready low for 5 cycles. Hold wr high with func 00 while data changes → only the value present at the rising edge is captured.
